// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce blocks (input and output side).
package debounce_pkg;

    typedef enum logic [2:0] {
        SM_LOW_HOLD   = 3'd0,
        SM_LOW_IDLE   = 3'd1,
        SM_HIGH_HOLD  = 3'd2,
        SM_HIGH_IDLE  = 3'd3,
        SM_PULSE_HIGH = 3'd4
    } dbo_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_output_dwell_timer.sv
// Shared dwell counter: cleared on demand, counts while enabled, flags when the terminal value is reached.
module dwell_timer #(
    parameter int unsigned G_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               en,
    input  logic [G_WIDTH-1:0] terminal,
    output logic               done_c
);

    logic [G_WIDTH-1:0] cnt_q;
    logic [G_WIDTH-1:0] cnt_d;

    assign done_c = (cnt_q == terminal);

    // Holding at the terminal value keeps the count from ever wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && !done_c) begin
            cnt_d = cnt_q + G_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/debounce_output.sv
// Output-side debouncer: drives a slow pin from level requests or queued fixed-width pulses,
// enforcing minimum high/low dwell times so the pin never chatters.
module debounce_output
    import debounce_pkg::*;
#(
    parameter  int unsigned G_MIN_HIGH_CYCLES   = 256,
    parameter  int unsigned G_MIN_LOW_CYCLES    = 256,
    parameter  int unsigned G_PULSE_HIGH_CYCLES = 16,
    parameter  int unsigned G_MAX_PENDING       = 4,
    localparam int unsigned PEND_W              = $clog2(G_MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              level_req,
    input  logic              pulse_valid,
    output logic              pulse_ready,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic              busy,
    output logic              dout
);

    localparam int unsigned CNT_W =
        $clog2(max_u(max_u(G_MIN_HIGH_CYCLES, G_MIN_LOW_CYCLES), G_PULSE_HIGH_CYCLES) + 1);
    localparam logic [CNT_W-1:0] TERM_HIGH  = CNT_W'(G_MIN_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_LOW   = CNT_W'(G_MIN_LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] TERM_PULSE = CNT_W'(G_PULSE_HIGH_CYCLES - 1);

    dbo_state_e        state_q, state_d;
    dbo_state_e        eval_state;
    logic              dout_q, dout_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;

    logic              timer_clear;
    logic              timer_en;
    logic [CNT_W-1:0]  timer_term;
    logic              timer_done;
    logic              start_pulse;
    logic              accept;

    dwell_timer #(
        .G_WIDTH (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .en       (timer_en),
        .terminal (timer_term),
        .done_c   (timer_done)
    );

    assign pulse_ready = mode && (pending_q < PEND_W'(G_MAX_PENDING));
    assign accept      = pulse_valid && pulse_ready;
    assign busy        = (state_q == SM_LOW_HOLD) || (state_q == SM_HIGH_HOLD)
                      || (state_q == SM_PULSE_HIGH);
    assign pending     = pending_q;
    assign overflow    = overflow_q;
    assign dout        = dout_q;

    // Next state: a hold whose dwell has elapsed is evaluated as its idle state in the same cycle,
    // so no idle cycle is inserted between the end of a hold and the next transition.
    always_comb begin
        state_d     = state_q;
        dout_d      = dout_q;
        eval_state  = state_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        timer_term  = TERM_LOW;
        start_pulse = 1'b0;

        case (state_q)
            SM_LOW_HOLD: begin
                timer_en   = 1'b1;
                timer_term = TERM_LOW;
                if (timer_done) begin
                    eval_state = SM_LOW_IDLE;
                    state_d    = SM_LOW_IDLE;
                end
            end
            SM_HIGH_HOLD: begin
                timer_en   = 1'b1;
                timer_term = TERM_HIGH;
                if (timer_done) begin
                    eval_state = SM_HIGH_IDLE;
                    state_d    = SM_HIGH_IDLE;
                end
            end
            SM_PULSE_HIGH: begin
                timer_en   = 1'b1;
                timer_term = TERM_PULSE;
            end
            default: ;
        endcase

        case (eval_state)
            SM_LOW_IDLE: begin
                if (!mode && level_req) begin
                    dout_d      = 1'b1;
                    state_d     = SM_HIGH_HOLD;
                    timer_clear = 1'b1;
                end else if (mode && (pending_q != '0)) begin
                    dout_d      = 1'b1;
                    state_d     = SM_PULSE_HIGH;
                    timer_clear = 1'b1;
                    start_pulse = 1'b1;
                end
            end
            SM_HIGH_IDLE: begin
                if (!level_req || mode) begin
                    dout_d      = 1'b0;
                    state_d     = SM_LOW_HOLD;
                    timer_clear = 1'b1;
                end
            end
            SM_PULSE_HIGH: begin
                if (timer_done) begin
                    dout_d      = 1'b0;
                    state_d     = SM_LOW_HOLD;
                    timer_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pending-pulse count and drop strobe; level mode flushes the queue.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = mode && pulse_valid && !pulse_ready;
        if (!mode) begin
            pending_d = '0;
        end else begin
            pending_d = pending_q + PEND_W'(accept) - PEND_W'(start_pulse);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SM_LOW_HOLD;
            dout_q     <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dout_q     <= dout_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_debounce_output.sv
// Scenario bench for debounce_output against a run-length based reference model.
module tb_debounce_output;

    localparam int unsigned MIN_HIGH = 4;
    localparam int unsigned MIN_LOW  = 3;
    localparam int unsigned PULSE    = 2;
    localparam int unsigned MAXP     = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode;
    logic       level_req;
    logic       pulse_valid;
    logic       pulse_ready;
    logic [1:0] pending;
    logic       overflow;
    logic       busy;
    logic       dout;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: current pin level, how many cycles it has held that level, whether the high run is a pulse.
    bit m_dout;
    bit m_pulse;
    bit m_ovf;
    int m_run;
    int m_pend;

    debounce_output #(
        .G_MIN_HIGH_CYCLES   (MIN_HIGH),
        .G_MIN_LOW_CYCLES    (MIN_LOW),
        .G_PULSE_HIGH_CYCLES (PULSE),
        .G_MAX_PENDING       (MAXP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mode        (mode),
        .level_req   (level_req),
        .pulse_valid (pulse_valid),
        .pulse_ready (pulse_ready),
        .pending     (pending),
        .overflow    (overflow),
        .busy        (busy),
        .dout        (dout)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] exp_vec();
        bit b;
        bit r;
        b = m_dout ? (m_pulse || (m_run <= int'(MIN_HIGH))) : (m_run <= int'(MIN_LOW));
        r = mode && (m_pend < int'(MAXP));
        return {m_dout, b, m_ovf, r, 2'(m_pend)};
    endfunction

    function automatic logic [5:0] obs_vec();
        return {dout, busy, overflow, pulse_ready, pending};
    endfunction

    // Advance one clock, updating the model from the inputs presented during the cycle.
    task automatic step();
        bit flip;
        bit start;
        bit ready;
        bit acc;
        int n_pend;
        bit n_ovf;
        flip  = 1'b0;
        start = 1'b0;
        ready = mode && (m_pend < int'(MAXP));
        acc   = mode && pulse_valid && ready;
        if (!m_dout) begin
            if (m_run >= int'(MIN_LOW)) begin
                if (!mode && level_req) flip = 1'b1;
                else if (mode && m_pend > 0) begin
                    flip  = 1'b1;
                    start = 1'b1;
                end
            end
        end else if (m_pulse) begin
            flip = (m_run == int'(PULSE));
        end else begin
            flip = (m_run >= int'(MIN_HIGH)) && (!level_req || mode);
        end
        n_pend = mode ? (m_pend + int'(acc) - int'(start)) : 0;
        n_ovf  = mode && pulse_valid && !ready;
        @(posedge clk);
        #1;
        if (reset) begin
            m_dout  = 1'b0;
            m_pulse = 1'b0;
            m_run   = 1;
            m_pend  = 0;
            m_ovf   = 1'b0;
        end else begin
            m_pend = n_pend;
            m_ovf  = n_ovf;
            if (flip) begin
                m_dout  = !m_dout;
                m_pulse = start;
                m_run   = 1;
            end else begin
                m_run++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b0; level_req = 1'b0; pulse_valid = 1'b0;
        step();
        step();
        tests_run++;
        if ({dout, pending, overflow} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 0000", {dout, pending, overflow});
        end
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b expected 1", busy);
        end
        tests_run++;
        if (obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_model: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_level_hold();
        int rise_at;
        int busy_cnt;
        reset = 1'b1; mode = 1'b0; level_req = 1'b1; pulse_valid = 1'b0;
        step();
        reset    = 1'b0;
        rise_at  = -1;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL level_hold_model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
            if (dout === 1'b1 && rise_at < 0) rise_at = i;
            if (busy === 1'b1) busy_cnt++;
        end
        tests_run++;
        if (rise_at != 3) begin
            tests_failed++;
            $display("FAIL level_hold_rise: got edge %0d expected 3", rise_at);
        end
        tests_run++;
        if (busy_cnt != 7) begin
            tests_failed++;
            $display("FAIL level_hold_busy: got %0d cycles expected 7", busy_cnt);
        end
    endtask

    task automatic test_level_glitch();
        int  hi_len;
        int  rises;
        bit  prev;
        int  guard;
        level_req = 1'b0;
        guard = 0;
        while (!(m_dout == 1'b0 && m_run > int'(MIN_LOW)) && guard < 20) begin
            step();
            guard++;
        end
        tests_run++;
        if (guard >= 20 || dout !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_settle: got dout %b after %0d cycles expected 0", dout, guard);
        end
        hi_len = 0;
        rises  = 0;
        prev   = dout;
        for (int i = 0; i < 17; i++) begin
            level_req = (i == 0);
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL glitch_model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
            if (dout === 1'b1) hi_len++;
            if (dout === 1'b1 && !prev) rises++;
            prev = dout;
        end
        tests_run++;
        if (hi_len != 4 || rises != 1) begin
            tests_failed++;
            $display("FAIL glitch_shape: got high=%0d rises=%0d expected high=4 rises=1", hi_len, rises);
        end
    endtask

    task automatic test_level_toggle();
        bit prev;
        int run;
        bit first;
        level_req = 1'(($urandom & 1));
        prev  = dout;
        run   = 0;
        first = 1'b1;
        for (int i = 0; i < 40; i++) begin
            level_req = !level_req;
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL toggle_model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
            if (dout !== prev) begin
                if (!first) begin
                    tests_run++;
                    if (run < int'(prev ? MIN_HIGH : MIN_LOW)) begin
                        tests_failed++;
                        $display("FAIL toggle_dwell: got run %0d at level %b expected >= %0d",
                                 run, prev, prev ? MIN_HIGH : MIN_LOW);
                    end
                end
                first = 1'b0;
                run   = 1;
                prev  = dout;
            end else begin
                run++;
            end
        end
    endtask

    task automatic test_pulse_b2b();
        int  ovf_cnt;
        int  rises;
        int  run;
        bit  prev;
        reset = 1'b1; mode = 1'b1; level_req = 1'b0; pulse_valid = 1'b0;
        step();
        reset   = 1'b0;
        ovf_cnt = 0;
        rises   = 0;
        run     = 1;
        prev    = dout;
        for (int i = 1; i <= 22; i++) begin
            pulse_valid = (i <= 3);
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL b2b_model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
            if (i == 2) begin
                tests_run++;
                if (pending !== 2'd2 || pulse_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_full: got pending=%0d ready=%b expected 2/0", pending, pulse_ready);
                end
            end
            if (overflow === 1'b1) ovf_cnt++;
            if (dout !== prev) begin
                tests_run++;
                if (prev && run != int'(PULSE)) begin
                    tests_failed++;
                    $display("FAIL b2b_width: got %0d expected %0d", run, PULSE);
                end else if (!prev && rises > 0 && run != int'(MIN_LOW)) begin
                    tests_failed++;
                    $display("FAIL b2b_gap: got %0d expected %0d", run, MIN_LOW);
                end
                if (!prev) rises++;
                run  = 1;
                prev = dout;
            end else begin
                run++;
            end
        end
        tests_run++;
        if (rises != 2 || ovf_cnt != 1) begin
            tests_failed++;
            $display("FAIL b2b_counts: got pulses=%0d overflow=%0d expected 2/1", rises, ovf_cnt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int guard;
        int highs;
        reset = 1'b1; mode = 1'b1; level_req = 1'b0; pulse_valid = 1'b0;
        step();
        reset = 1'b0;
        pulse_valid = 1'b1;
        step();
        step();
        pulse_valid = 1'b0;
        guard = 0;
        while (dout !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        tests_run++;
        if (dout !== 1'b1 || pending !== 2'd1) begin
            tests_failed++;
            $display("FAIL midpulse_setup: got dout=%b pending=%0d expected 1/1", dout, pending);
        end
        reset = 1'b1;
        step();
        tests_run++;
        if (dout !== 1'b0 || pending !== 2'd0) begin
            tests_failed++;
            $display("FAIL midpulse_reset: got dout=%b pending=%0d expected 0/0", dout, pending);
        end
        reset = 1'b0;
        highs = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (dout === 1'b1) highs++;
        end
        tests_run++;
        if (highs != 0 || obs_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL midpulse_after: got highs=%0d vec=%b expected 0 and %b", highs, obs_vec(), exp_vec());
        end
    endtask

    task automatic test_mode_switch();
        int guard;
        reset = 1'b1; mode = 1'b1; level_req = 1'b0; pulse_valid = 1'b0;
        step();
        reset = 1'b0;
        pulse_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        pulse_valid = 1'b0;
        tests_run++;
        if (dout !== 1'b1 || pending !== 2'd2) begin
            tests_failed++;
            $display("FAIL modesw_setup: got dout=%b pending=%0d expected 1/2", dout, pending);
        end
        mode = 1'b0;
        level_req = 1'b1;
        step();
        tests_run++;
        if (dout !== 1'b0 || pending !== 2'd0 || pulse_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL modesw_end: got dout=%b pending=%0d ready=%b expected 0/0/0",
                     dout, pending, pulse_ready);
        end
        guard = 0;
        while (dout !== 1'b1 && guard < 10) begin
            step();
            guard++;
        end
        tests_run++;
        if (guard != int'(MIN_LOW)) begin
            tests_failed++;
            $display("FAIL modesw_level: got rise after %0d cycles expected %0d", guard, MIN_LOW);
        end
        level_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL modesw_model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        reset = 1'b1; pulse_valid = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) mode = !mode;
            level_req   = 1'($urandom & 1);
            pulse_valid = 1'($urandom & 1);
            step();
            tests_run++;
            if (obs_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random_model cyc %0d: got %b expected %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1; mode = 1'b0; level_req = 1'b0; pulse_valid = 1'b0;
        m_dout = 1'b0; m_pulse = 1'b0; m_ovf = 1'b0; m_run = 1; m_pend = 0;
        test_reset();
        test_level_hold();
        test_level_glitch();
        test_level_toggle();
        test_pulse_b2b();
        test_reset_mid_pulse();
        test_mode_switch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
